// File: rtl/id_ex_stage_pkg.sv
// Shared encodings for the ID/EX stage: ALU opcodes, operand selects and FSM states.
package id_ex_stage_pkg;

    localparam logic [3:0] ALU_NONE = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;
    localparam logic [3:0] ALU_SLT  = 4'd9;
    localparam logic [3:0] ALU_SLTU = 4'd10;

    localparam logic SRC_A_RS1 = 1'b0;
    localparam logic SRC_A_PC  = 1'b1;
    localparam logic SRC_B_RS2 = 1'b0;
    localparam logic SRC_B_IMM = 1'b1;

    typedef enum logic [1:0] {
        IDEX_EMPTY  = 2'd0,
        IDEX_FULL   = 2'd1,
        IDEX_HAZARD = 2'd2
    } idex_state_e;

endpackage

// File: rtl/id_ex_stage_operand_fwd_mux.sv
// Per-source operand resolution: MEM (non-load) beats WB beats the held value.
// Also flags a load-use hazard and a WB hit used to refresh the held copy.
module id_ex_stage_operand_fwd_mux #(
    parameter int XLEN   = 32,
    parameter int RIDX_W = 5
) (
    input  logic [RIDX_W-1:0] i_idx,
    input  logic [XLEN-1:0]   i_held,
    input  logic              i_mem_we,
    input  logic [RIDX_W-1:0] i_mem_rd,
    input  logic [XLEN-1:0]   i_mem_data,
    input  logic              i_mem_is_load,
    input  logic              i_wb_we,
    input  logic [RIDX_W-1:0] i_wb_rd,
    input  logic [XLEN-1:0]   i_wb_data,
    output logic [XLEN-1:0]   o_value,
    output logic              o_wb_hit,
    output logic              o_load_hazard
);

    logic w_nz;
    logic w_mem_hit;

    // x0 is hard-wired zero, so it never matches a producer.
    assign w_nz          = |i_idx;
    assign w_mem_hit     = i_mem_we & (i_mem_rd == i_idx) & w_nz;
    assign o_wb_hit      = i_wb_we & (i_wb_rd == i_idx) & w_nz;
    assign o_load_hazard = w_mem_hit & i_mem_is_load;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        o_value = i_held;
        if (w_mem_hit && !i_mem_is_load) begin
            o_value = i_mem_data;
        end else if (o_wb_hit) begin
            o_value = i_wb_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: holds one decoded instruction,
// forwards from MEM/WB, bubbles on load-use and drops its contents on flush.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int RIDX_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [3:0]        in_op_i,
    input  logic [XLEN-1:0]   in_pc_i,
    input  logic [RIDX_W-1:0] in_rs1_idx_i,
    input  logic [RIDX_W-1:0] in_rs2_idx_i,
    input  logic [XLEN-1:0]   in_rs1_data_i,
    input  logic [XLEN-1:0]   in_rs2_data_i,
    input  logic [XLEN-1:0]   in_imm_i,
    input  logic              in_a_sel_i,
    input  logic              in_b_sel_i,
    input  logic [RIDX_W-1:0] in_rd_i,
    input  logic              in_rd_we_i,
    input  logic              flush_i,
    input  logic              mem_we_i,
    input  logic [RIDX_W-1:0] mem_rd_i,
    input  logic [XLEN-1:0]   mem_data_i,
    input  logic              mem_is_load_i,
    input  logic              wb_we_i,
    input  logic [RIDX_W-1:0] wb_rd_i,
    input  logic [XLEN-1:0]   wb_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [3:0]        op_o,
    output logic [XLEN-1:0]   a_o,
    output logic [XLEN-1:0]   b_o,
    output logic [XLEN-1:0]   rs2_fwd_o,
    output logic [RIDX_W-1:0] rd_o,
    output logic              rd_we_o,
    output logic [XLEN-1:0]   pc_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    idex_state_e       r_state;
    idex_state_e       w_next_state;
    logic [3:0]        r_op;
    logic [XLEN-1:0]   r_pc;
    logic [RIDX_W-1:0] r_rs1_idx;
    logic [RIDX_W-1:0] r_rs2_idx;
    logic [XLEN-1:0]   r_rs1_data;
    logic [XLEN-1:0]   r_rs2_data;
    logic [XLEN-1:0]   r_imm;
    logic              r_a_sel;
    logic              r_b_sel;
    logic [RIDX_W-1:0] r_rd;
    logic              r_rd_we;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic [XLEN-1:0]   w_rs1_fwd;
    logic [XLEN-1:0]   w_rs2_fwd;
    logic              w_rs1_wb_hit;
    logic              w_rs2_wb_hit;
    logic              w_rs1_lh;
    logic              w_rs2_lh;
    logic              w_held_hazard;
    logic              w_in_rs1_lh;
    logic              w_in_rs2_lh;
    logic              w_in_hazard;
    logic              w_load;

    id_ex_stage_operand_fwd_mux #(.XLEN(XLEN), .RIDX_W(RIDX_W)) u_fwd_rs1 (
        .i_idx(r_rs1_idx), .i_held(r_rs1_data),
        .i_mem_we(mem_we_i), .i_mem_rd(mem_rd_i), .i_mem_data(mem_data_i),
        .i_mem_is_load(mem_is_load_i),
        .i_wb_we(wb_we_i), .i_wb_rd(wb_rd_i), .i_wb_data(wb_data_i),
        .o_value(w_rs1_fwd), .o_wb_hit(w_rs1_wb_hit), .o_load_hazard(w_rs1_lh)
    );

    id_ex_stage_operand_fwd_mux #(.XLEN(XLEN), .RIDX_W(RIDX_W)) u_fwd_rs2 (
        .i_idx(r_rs2_idx), .i_held(r_rs2_data),
        .i_mem_we(mem_we_i), .i_mem_rd(mem_rd_i), .i_mem_data(mem_data_i),
        .i_mem_is_load(mem_is_load_i),
        .i_wb_we(wb_we_i), .i_wb_rd(wb_rd_i), .i_wb_data(wb_data_i),
        .o_value(w_rs2_fwd), .o_wb_hit(w_rs2_wb_hit), .o_load_hazard(w_rs2_lh)
    );

    // rs2 is a live source when it feeds b, or as store data (imm-based, no rd write).
    assign w_held_hazard = ((r_a_sel == SRC_A_RS1) & w_rs1_lh) |
                           (((r_b_sel == SRC_B_RS2) | ~r_rd_we) & w_rs2_lh);

    assign w_in_rs1_lh = mem_we_i & mem_is_load_i & (mem_rd_i == in_rs1_idx_i) & (|in_rs1_idx_i);
    assign w_in_rs2_lh = mem_we_i & mem_is_load_i & (mem_rd_i == in_rs2_idx_i) & (|in_rs2_idx_i);
    assign w_in_hazard = ((in_a_sel_i == SRC_A_RS1) & w_in_rs1_lh) |
                         (((in_b_sel_i == SRC_B_RS2) | ~in_rd_we_i) & w_in_rs2_lh);

    assign in_ready_o = (r_state == IDEX_EMPTY) | ((r_state == IDEX_FULL) & out_ready_i);
    assign w_load     = in_valid_i & in_ready_o & ~flush_i;

    always_comb begin
        w_next_state = r_state;
        if (flush_i) begin
            w_next_state = IDEX_EMPTY;
        end else if (w_load) begin
            w_next_state = w_in_hazard ? IDEX_HAZARD : IDEX_FULL;
        end else begin
            case (r_state)
                IDEX_FULL: begin
                    if (out_ready_i)        w_next_state = IDEX_EMPTY;
                    else if (w_held_hazard) w_next_state = IDEX_HAZARD;
                end
                IDEX_HAZARD: w_next_state = w_held_hazard ? IDEX_HAZARD : IDEX_FULL;
                default:     w_next_state = IDEX_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDEX_EMPTY;
        end else begin
            // NOTE: state elements use non-blocking assignments so every register samples pre-edge values.
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_op        <= ALU_NONE;
            r_pc        <= '0;
            r_rs1_idx   <= '0;
            r_rs2_idx   <= '0;
            r_rs1_data  <= '0;
            r_rs2_data  <= '0;
            r_imm       <= '0;
            r_a_sel     <= 1'b0;
            r_b_sel     <= 1'b0;
            r_rd        <= '0;
            r_rd_we     <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            if ((r_state == IDEX_HAZARD) && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (flush_i) begin
                r_op    <= ALU_NONE;
                r_rd_we <= 1'b0;
            end else if (w_load) begin
                r_op       <= in_op_i;
                r_pc       <= in_pc_i;
                r_rs1_idx  <= in_rs1_idx_i;
                r_rs2_idx  <= in_rs2_idx_i;
                r_rs1_data <= in_rs1_data_i;
                r_rs2_data <= in_rs2_data_i;
                r_imm      <= in_imm_i;
                r_a_sel    <= in_a_sel_i;
                r_b_sel    <= in_b_sel_i;
                r_rd       <= in_rd_i;
                r_rd_we    <= in_rd_we_i;
            end else if (r_state != IDEX_EMPTY) begin
                // Capture a value retiring from WB so a long stall does not lose it.
                if (w_rs1_wb_hit) r_rs1_data <= wb_data_i;
                if (w_rs2_wb_hit) r_rs2_data <= wb_data_i;
            end
        end
    end

    assign out_valid_o = (r_state == IDEX_FULL);
    assign op_o        = r_op;
    assign a_o         = (r_a_sel == SRC_A_PC)  ? r_pc  : w_rs1_fwd;
    assign b_o         = (r_b_sel == SRC_B_IMM) ? r_imm : w_rs2_fwd;
    assign rs2_fwd_o   = w_rs2_fwd;
    assign rd_o        = r_rd;
    assign rd_we_o     = r_rd_we & ~flush_i;
    assign pc_o        = r_pc;
    assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: forwarding, load-use bubble,
// held-operand refresh, x0, flush and asynchronous reset.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [3:0]  in_op_i;
    logic [31:0] in_pc_i;
    logic [4:0]  in_rs1_idx_i;
    logic [4:0]  in_rs2_idx_i;
    logic [31:0] in_rs1_data_i;
    logic [31:0] in_rs2_data_i;
    logic [31:0] in_imm_i;
    logic        in_a_sel_i;
    logic        in_b_sel_i;
    logic [4:0]  in_rd_i;
    logic        in_rd_we_i;
    logic        flush_i;
    logic        mem_we_i;
    logic [4:0]  mem_rd_i;
    logic [31:0] mem_data_i;
    logic        mem_is_load_i;
    logic        wb_we_i;
    logic [4:0]  wb_rd_i;
    logic [31:0] wb_data_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [3:0]  op_o;
    logic [31:0] a_o;
    logic [31:0] b_o;
    logic [31:0] rs2_fwd_o;
    logic [4:0]  rd_o;
    logic        rd_we_o;
    logic [31:0] pc_o;
    logic [15:0] stall_cnt_o;

    int errors = 0;
    int checks = 0;

    id_ex_stage dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_op_i(in_op_i), .in_pc_i(in_pc_i),
        .in_rs1_idx_i(in_rs1_idx_i), .in_rs2_idx_i(in_rs2_idx_i),
        .in_rs1_data_i(in_rs1_data_i), .in_rs2_data_i(in_rs2_data_i),
        .in_imm_i(in_imm_i), .in_a_sel_i(in_a_sel_i), .in_b_sel_i(in_b_sel_i),
        .in_rd_i(in_rd_i), .in_rd_we_i(in_rd_we_i), .flush_i(flush_i),
        .mem_we_i(mem_we_i), .mem_rd_i(mem_rd_i), .mem_data_i(mem_data_i),
        .mem_is_load_i(mem_is_load_i),
        .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .op_o(op_o), .a_o(a_o), .b_o(b_o), .rs2_fwd_o(rs2_fwd_o),
        .rd_o(rd_o), .rd_we_o(rd_we_o), .pc_o(pc_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven from here.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_instr(input logic [3:0] op, input logic [31:0] pc,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [31:0] d1, input logic [31:0] d2,
                               input logic [31:0] imm, input logic asel, input logic bsel,
                               input logic [4:0] rd, input logic rdwe);
        in_valid_i    = 1'b1;
        in_op_i       = op;
        in_pc_i       = pc;
        in_rs1_idx_i  = rs1;
        in_rs2_idx_i  = rs2;
        in_rs1_data_i = d1;
        in_rs2_data_i = d2;
        in_imm_i      = imm;
        in_a_sel_i    = asel;
        in_b_sel_i    = bsel;
        in_rd_i       = rd;
        in_rd_we_i    = rdwe;
    endtask

    task automatic set_mem(input logic we, input logic [4:0] rd, input logic [31:0] d, input logic ld);
        mem_we_i = we; mem_rd_i = rd; mem_data_i = d; mem_is_load_i = ld;
    endtask

    task automatic set_wb(input logic we, input logic [4:0] rd, input logic [31:0] d);
        wb_we_i = we; wb_rd_i = rd; wb_data_i = d;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i = 1'b1;
        in_valid_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b0;
        drive_instr(ALU_NONE, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0);
        in_valid_i = 1'b0;
        set_mem(1'b0, 5'd0, 32'h0, 1'b0);
        set_wb(1'b0, 5'd0, 32'h0);
        #12;
        check("rst_valid", 32'(out_valid_o), 32'd0);
        check("rst_op", 32'(op_o), 32'(ALU_NONE));
        check("rst_stall", 32'(stall_cnt_o), 32'd0);
        check("rst_ready", 32'(in_ready_o), 32'd1);
        check("rst_rd_we", 32'(rd_we_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // 1: back-to-back ADDs, second one forwarded from MEM (MEM beats WB)
        tick();
        out_ready_i = 1'b1;
        drive_instr(ALU_ADD, 32'h100, 5'd1, 5'd2, 32'h1, 32'h2, 32'h0, SRC_A_RS1, SRC_B_RS2, 5'd3, 1'b1);
        tick();
        drive_instr(ALU_ADD, 32'h104, 5'd3, 5'd3, 32'h0, 32'h0, 32'h0, SRC_A_RS1, SRC_B_RS2, 5'd4, 1'b1);
        #1;
        check("t1_valid0", 32'(out_valid_o), 32'd1);
        check("t1_a0", a_o, 32'h1);
        check("t1_b0", b_o, 32'h2);
        check("t1_op0", 32'(op_o), 32'(ALU_ADD));
        check("t1_pc0", pc_o, 32'h100);
        check("t1_ready0", 32'(in_ready_o), 32'd1);
        tick();
        in_valid_i = 1'b0;
        set_mem(1'b1, 5'd3, 32'h10, 1'b0);
        set_wb(1'b1, 5'd3, 32'h99);
        #1;
        check("t1_valid1", 32'(out_valid_o), 32'd1);
        check("t1_a1_memfwd", a_o, 32'h10);
        check("t1_b1_memfwd", b_o, 32'h10);
        check("t1_rd1", 32'(rd_o), 32'd4);
        tick();
        set_mem(1'b0, 5'd0, 32'h0, 1'b0);
        set_wb(1'b0, 5'd0, 32'h0);
        #1;
        check("t1_drain", 32'(out_valid_o), 32'd0);

        // 2: load-use bubble, then WB value captured into the held operand
        drive_instr(ALU_SUB, 32'h200, 5'd5, 5'd1, 32'h0, 32'h3, 32'h0, SRC_A_RS1, SRC_B_RS2, 5'd6, 1'b1);
        set_mem(1'b1, 5'd5, 32'hBAD, 1'b1);
        tick();
        in_valid_i = 1'b0;
        set_mem(1'b0, 5'd0, 32'h0, 1'b0);
        set_wb(1'b1, 5'd5, 32'hDEAD);
        #1;
        check("t2_bubble", 32'(out_valid_o), 32'd0);
        check("t2_stall0", 32'(stall_cnt_o), 32'd0);
        check("t2_ready_hz", 32'(in_ready_o), 32'd0);
        tick();
        set_wb(1'b0, 5'd0, 32'h0);
        #1;
        check("t2_valid", 32'(out_valid_o), 32'd1);
        check("t2_stall1", 32'(stall_cnt_o), 32'd1);
        check("t2_a_held", a_o, 32'hDEAD);
        check("t2_b", b_o, 32'h3);
        check("t2_op", 32'(op_o), 32'(ALU_SUB));
        tick();
        out_ready_i = 1'b0;
        drive_instr(ALU_ADD, 32'h300, 5'd8, 5'd9, 32'h20, 32'h11, 32'h0, SRC_A_RS1, SRC_B_RS2, 5'd7, 1'b1);

        // 3: downstream stalled 3 cycles while WB retires rs2
        tick();
        in_valid_i = 1'b0;
        set_wb(1'b1, 5'd9, 32'h55);
        #1;
        check("t3_valid", 32'(out_valid_o), 32'd1);
        check("t3_b_wbfwd", b_o, 32'h55);
        check("t3_ready_blk", 32'(in_ready_o), 32'd0);
        tick();
        set_wb(1'b0, 5'd0, 32'h0);
        #1;
        check("t3_b_held", b_o, 32'h55);
        check("t3_rs2fwd", rs2_fwd_o, 32'h55);
        tick();
        out_ready_i = 1'b1;
        #1;
        check("t3_b_release", b_o, 32'h55);
        check("t3_a_release", a_o, 32'h20);
        check("t3_ready_rel", 32'(in_ready_o), 32'd1);
        tick();
        #1;
        check("t3_drain", 32'(out_valid_o), 32'd0);
        check("t3_stall_same", 32'(stall_cnt_o), 32'd1);

        // 4: x0 is never forwarded and never causes a load hazard
        out_ready_i = 1'b0;
        drive_instr(ALU_ADD, 32'h400, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, SRC_A_RS1, SRC_B_RS2, 5'd10, 1'b1);
        set_mem(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1);
        tick();
        in_valid_i = 1'b0;
        set_mem(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0);
        set_wb(1'b1, 5'd0, 32'hAAAA);
        #1;
        check("t4_valid", 32'(out_valid_o), 32'd1);
        check("t4_a_x0", a_o, 32'h0);
        check("t4_b_x0", b_o, 32'h0);

        // 5: flush in FULL drops held and incoming instruction
        set_mem(1'b0, 5'd0, 32'h0, 1'b0);
        set_wb(1'b0, 5'd0, 32'h0);
        out_ready_i = 1'b1;
        drive_instr(ALU_OR, 32'h500, 5'd1, 5'd2, 32'h1, 32'h2, 32'h0, SRC_A_RS1, SRC_B_RS2, 5'd11, 1'b1);
        #1;
        check("t5_rd_we_pre", 32'(rd_we_o), 32'd1);
        flush_i = 1'b1;
        #1;
        check("t5_rd_we_flush", 32'(rd_we_o), 32'd0);
        tick();
        flush_i = 1'b0;
        in_valid_i = 1'b0;
        #1;
        check("t5_empty", 32'(out_valid_o), 32'd0);
        check("t5_rd_we_after", 32'(rd_we_o), 32'd0);
        check("t5_ready", 32'(in_ready_o), 32'd1);

        // 6: store data rs2 load-use hazard, then async reset mid-HAZARD
        drive_instr(ALU_ADD, 32'h600, 5'd1, 5'd5, 32'h4, 32'h0, 32'h8, SRC_A_RS1, SRC_B_IMM, 5'd0, 1'b0);
        set_mem(1'b1, 5'd5, 32'h0, 1'b1);
        tick();
        in_valid_i = 1'b0;
        #1;
        check("t6_bubble0", 32'(out_valid_o), 32'd0);
        tick();
        #1;
        check("t6_bubble1", 32'(out_valid_o), 32'd0);
        check("t6_stall2", 32'(stall_cnt_o), 32'd2);
        check("t6_op_pre", 32'(op_o), 32'(ALU_ADD));
        rst_i = 1'b1;
        #1;
        check("t6_rst_valid", 32'(out_valid_o), 32'd0);
        check("t6_rst_op", 32'(op_o), 32'(ALU_NONE));
        check("t6_rst_stall", 32'(stall_cnt_o), 32'd0);
        check("t6_rst_a", a_o, 32'h0);
        check("t6_rst_ready", 32'(in_ready_o), 32'd1);
        @(negedge clk_i);
        rst_i = 1'b0;
        set_mem(1'b0, 5'd0, 32'h0, 1'b0);
        tick();
        #1;
        check("t6_post_rst", 32'(out_valid_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
